// File: rtl/life_pkg.sv
// Shared definitions for the Life board sequencer.
//   DIM          board edge length (the board is DIM x DIM cells)
//   board_t      packed board image, indexed [row][col]
//   state_t      sequencer FSM states (the encoding is visible on state_o)
//   pattern_t    seed selector values driven on pattern_sel
//   pattern_rom  maps a selector to its seed board image
package life_pkg;

   localparam int DIM = 16;

   typedef logic [DIM-1:0][DIM-1:0] board_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_CHECK = 3'd4,
      ST_HALT  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      PAT_BLANK   = 2'd0,
      PAT_GLIDER  = 2'd1,
      PAT_BLINKER = 2'd2,
      PAT_RPENT   = 2'd3
   } pattern_t;

   // Each seed is written row 15 first, row 0 last; bit c of a row is column c.
   localparam board_t SEED_BLANK   = '0;
   // Rows 1..3: .X. / ..X / XXX at columns 1..3
   localparam board_t SEED_GLIDER  = {192'h0, 16'h000E, 16'h0008, 16'h0004, 16'h0000};
   // Row 7, columns 6..8
   localparam board_t SEED_BLINKER = {128'h0, 16'h01C0, 112'h0};
   // Rows 6..8: .XX / XX. / .X. around column 7
   localparam board_t SEED_RPENT   = {112'h0, 16'h0080, 16'h00C0, 16'h0180, 96'h0};

   function automatic board_t pattern_rom(input pattern_t sel);
      board_t b;
      case (sel)
         PAT_GLIDER:  b = SEED_GLIDER;
         PAT_BLINKER: b = SEED_BLINKER;
         PAT_RPENT:   b = SEED_RPENT;
         default:     b = SEED_BLANK;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Generation pacing for the Life sequencer.
// A prescaler produces one base tick every TICK_DIV enabled cycles; a speed
// counter then fires step_tick on every (speed+1)-th base tick.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   en         count this cycle (low = frozen, state is kept)
//   clr        synchronous clear of both counters
//   speed      generation period in base ticks, minus one
//   step_tick  one-cycle pulse: time for the next generation
module tick_divider #(
   parameter int TICK_DIV = 50_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   input  logic [3:0] speed,
   output logic       step_tick
);

   localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;
   logic [3:0]    tick_cnt;
   logic          base_tick;

   assign base_tick = en && (presc == PRESC_MAX);
   // ">=" rather than "==": if speed is lowered below the current count, the
   // step fires on the very next base tick instead of wrapping through 15.
   assign step_tick = base_tick && (tick_cnt >= speed);

   // NOTE: sequential state is always assigned with <= so every register
   // samples its inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc    <= '0;
         tick_cnt <= '0;
      end else if (clr) begin
         presc    <= '0;
         tick_cnt <= '0;
      end else if (en) begin
         presc <= base_tick ? '0 : presc + PW'(1);
         if (base_tick) begin
            tick_cnt <= step_tick ? 4'd0 : tick_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/life_sequencer.sv
// Run/pause/step controller for the 16x16 Life board array.
// Loads a seed pattern, paces generations through tick_divider, and halts when
// a generation leaves the board empty or unchanged.
// Ports:
//   clk             system clock
//   reset           asynchronous, active-low reset
//   start           level: run generations
//   pause           level: hold the board (wins over start)
//   step_once       pulse: advance one generation while paused
//   load_req        pulse: load the seed chosen by pattern_sel (highest priority)
//   pattern_sel     0 blank, 1 glider, 2 blinker, 3 R-pentomino
//   speed           generation period = (speed+1) base ticks
//   pixels          current board image from the array
//   board_load      one-cycle load strobe to the array
//   board_step      one-cycle generation-advance strobe to the array
//   initial_pixels  seed image, stable while board_load is high
//   gen_count       generations since last load, saturating
//   state_o         encoded FSM state
//   halted          board is extinct or a still life
module life_sequencer
   import life_pkg::*;
#(
   parameter int TICK_DIV = 50_000,
   parameter int GEN_W    = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       pause,
   input  logic                       step_once,
   input  logic                       load_req,
   input  logic [1:0]                 pattern_sel,
   input  logic [3:0]                 speed,
   input  logic [DIM-1:0][DIM-1:0]    pixels,
   output logic                       board_load,
   output logic                       board_step,
   output logic [DIM-1:0][DIM-1:0]    initial_pixels,
   output logic [GEN_W-1:0]           gen_count,
   output logic [2:0]                 state_o,
   output logic                       halted
);

   localparam logic [GEN_W-1:0] GEN_MAX = '1;

   state_t state;
   state_t origin;      // state to return to after CHECK (RUN or PAUSE)
   board_t snapshot;    // board as it was before the last step
   logic   run_mode;
   logic   div_en;
   logic   div_clr;
   logic   step_tick;

   // The step and CHECK cycles of a running board still count toward the
   // period, so generations stay exactly (speed+1)*TICK_DIV cycles apart.
   assign run_mode = (state == ST_RUN) || (state == ST_CHECK && origin == ST_RUN);
   assign div_en   = run_mode && !pause && !load_req;
   assign div_clr  = (state == ST_LOAD);
   assign state_o  = state;

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .clk       (clk),
      .reset     (reset),
      .en        (div_en),
      .clr       (div_clr),
      .speed     (speed),
      .step_tick (step_tick)
   );

   // board_step is issued from RUN/PAUSE and stays in that state for its one
   // high cycle; the edge that ends it is the edge on which the array advances,
   // so the snapshot is taken then and CHECK sees the new board next cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the snapshot is a plain register, not a memory, so it is
         // reset along with the rest of the state for a defined power-up image.
         state          <= ST_IDLE;
         origin         <= ST_PAUSE;
         snapshot       <= '0;
         board_load     <= 1'b0;
         board_step     <= 1'b0;
         initial_pixels <= '0;
         gen_count      <= '0;
         halted         <= 1'b0;
      end else begin
         board_load <= 1'b0;
         board_step <= 1'b0;
         if (load_req) begin
            state          <= ST_LOAD;
            board_load     <= 1'b1;
            initial_pixels <= pattern_rom(pattern_t'(pattern_sel));
            gen_count      <= '0;
            halted         <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_IDLE;
               end
               ST_LOAD: begin
                  state <= ST_PAUSE;
               end
               ST_PAUSE: begin
                  if (board_step) begin
                     snapshot <= pixels;
                     origin   <= ST_PAUSE;
                     state    <= ST_CHECK;
                  end else if (start && !pause) begin
                     state <= ST_RUN;
                  end else if (step_once) begin
                     // Single-stepping works with the pause switch held high.
                     board_step <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (board_step) begin
                     snapshot <= pixels;
                     origin   <= ST_RUN;
                     state    <= ST_CHECK;
                  end else if (pause) begin
                     state <= ST_PAUSE;
                  end else if (step_tick) begin
                     board_step <= 1'b1;
                  end
               end
               ST_CHECK: begin
                  if (gen_count != GEN_MAX) begin
                     gen_count <= gen_count + GEN_W'(1);
                  end
                  // Only period-1 patterns and empty boards stop the run.
                  if (pixels == '0 || pixels == snapshot) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else begin
                     state <= origin;
                  end
               end
               ST_HALT: begin
                  state <= ST_HALT;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
